fifo_to_app_wr_n: RTL
=====================

FIFO_TO_APP_WR_N -- requirements
Module: fifo_to_app_wr_n

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; clock port `clk`, reset port `reset`.
REQ-002 SHALL have parameter DATA_W, default 64: app data width per beat, multiple of 8.
REQ-003 SHALL have parameter BEATS, default 2: beats per burst, 1..8.
REQ-004 SHALL have parameter ADDR_W, default 27: app address width.
REQ-005 SHALL have parameter ALIGN_BITS, default 3: address LSBs forced to zero.
REQ-006 SHALL have parameter LEAD_MAX, default 4: maximum data bursts written ahead of commands, 1..15.
REQ-007 SHALL have ports:
- clk  in  1  clock
- reset  in  1  async active-high reset
- has_wr_data  in  1  data FIFO non-empty
- get_wr_data  out  1  data FIFO pop; data valid the next cycle
- write_data_in  in  DATA_W*BEATS  burst; beat0 in the LSBs
- has_wr_adx  in  1  address FIFO non-empty
- get_wr_adx  out  1  address FIFO pop; address valid the next cycle
- address_in  in  ADDR_W  write address
- write_data_out  out  DATA_W  app_wdf_data
- app_wdf_wren  out  1  write-data valid
- app_wdf_end  out  1  last beat of burst
- app_wdf_rdy  in  1  controller accepts data
- app_en  out  1  command valid
- app_cmd  out  3  constant 3'b000 (write)
- address_out  out  ADDR_W  app_addr
- app_rdy  in  1  controller accepts command
- credit_count  out  4  bursts written but not yet commanded

Function
REQ-010 Data FSM SHALL have states D_IDLE, D_LOAD and D_BEAT. Command FSM SHALL have states C_IDLE, C_LOAD and C_ISSUE. The two FSMs run independently.
REQ-011 In D_IDLE, get_wr_data SHALL equal has_wr_data && credit_count<LEAD_MAX; on a pop the FSM goes to D_LOAD.
REQ-012 D_LOAD SHALL register write_data_in into the burst register, clear the beat counter, and go to D_BEAT.
REQ-013 D_BEAT SHALL drive app_wdf_wren=1 and write_data_out=beat slice [beat*DATA_W +: DATA_W].
- The beat counter SHALL advance only on app_wdf_rdy.
- app_wdf_end SHALL be 1 only when beat==BEATS-1.
REQ-014 When the last beat is accepted, the data path SHALL:
- increment the credit;
- pop again (same cycle) and go to D_LOAD if has_wr_data && post-update credit<LEAD_MAX;
- otherwise go to D_IDLE.
REQ-015 When BEATS=1, every beat SHALL assert app_wdf_end.
REQ-016 In C_IDLE, get_wr_adx SHALL equal has_wr_adx && credit_count>0; on a pop the FSM goes to C_LOAD.
REQ-017 C_LOAD SHALL register {address_in[ADDR_W-1:ALIGN_BITS], ALIGN_BITS zeros} and go to C_ISSUE.
REQ-018 C_ISSUE SHALL hold app_en=1 and address_out stable until app_rdy. On acceptance it SHALL decrement the credit, then:
- pop and go to C_LOAD if has_wr_adx && post-update credit>0;
- otherwise go to C_IDLE.
REQ-019 Credit accounting:
- Simultaneous increment and decrement SHALL leave the credit unchanged.
- The credit SHALL never exceed LEAD_MAX or go below 0.
- A command SHALL never be issued before its data burst has completed.
REQ-020 When the corresponding valid is low, write_data_out SHALL be all-ones and address_out all-ones.
REQ-021 Outputs SHALL be glitch-free functions of state and registers. app_wdf_rdy and app_rdy SHALL gate only get_* and next state.

Reset
REQ-030 Asserting reset SHALL asynchronously force:
- D_IDLE and C_IDLE;
- credit 0 and beat counter 0;
- all strobes 0;
- data and address outputs all-ones.
REQ-031 Reset mid-burst or mid-command SHALL abandon the transfer; popped entries are discarded and not replayed.

Configuration
REQ-040 Macro WR_MASK_EN enabled: the block SHALL add input write_mask_in [DATA_W/8*BEATS] and output app_wdf_mask [DATA_W/8].
- The mask SHALL be registered with the data in D_LOAD.
- The mask SHALL be sliced per beat like the data.
- app_wdf_mask SHALL be 0 when app_wdf_wren is low.
REQ-041 Macro WR_MASK_EN disabled: neither mask port SHALL exist; the controller mask is tied to zero externally.

Verification
REQ-050 Base case. Stimulus: DATA_W=64, BEATS=2; one burst 128'hA..B and address 27'h0000_0ABC; rdys high. Required response:
- beats 64'hB then 64'hA;
- end on beat 1;
- after that, app_en with address_out=27'h0000_0AB8;
- credit returns to 0.
REQ-051 Address before data. Stimulus: address available 10 cycles before data. Required response:
- get_wr_adx stays 0 until credit=1;
- the command follows the burst completion.
REQ-052 Lead limit. Stimulus: 6 bursts queued, no addresses, LEAD_MAX=4. Required response:
- exactly 4 bursts are written;
- credit_count=4;
- get_wr_data stays 0.
REQ-053 Backpressure and simultaneous credit events. Stimulus: app_wdf_rdy toggling every cycle; app_rdy low 5 cycles. Required response:
- each beat is held until accepted;
- address_out is stable while app_en waits;
- a last beat and a command accepted in the same cycle leave the credit unchanged.
REQ-054 Reset mid-burst. Stimulus: reset during beat 1 of BEATS=4. Required response:
- all strobes 0 immediately;
- credit 0;
- the next burst starts at beat 0.

Source files
------------

// File: rtl/fifo_to_app_wr_n_if.sv
// Signal bundle between the write/address FIFOs, fifo_to_app_wr_n and the memory-controller app port.
// The mask pair is present only when WR_MASK_EN is defined.
interface fifo_to_app_wr_n_if #(
  parameter int DATA_W = 64,
  parameter int BEATS  = 2,
  parameter int ADDR_W = 27
);
  logic                    has_wr_data;
  logic                    get_wr_data;
  logic [DATA_W*BEATS-1:0] write_data_in;
  logic                    has_wr_adx;
  logic                    get_wr_adx;
  logic [ADDR_W-1:0]       address_in;
  logic [DATA_W-1:0]       write_data_out;
  logic                    app_wdf_wren;
  logic                    app_wdf_end;
  logic                    app_wdf_rdy;
  logic                    app_en;
  logic [2:0]              app_cmd;
  logic [ADDR_W-1:0]       address_out;
  logic                    app_rdy;
  logic [3:0]              credit_count;
`ifdef WR_MASK_EN
  logic [DATA_W/8*BEATS-1:0] write_mask_in;
  logic [DATA_W/8-1:0]       app_wdf_mask;
`endif

  modport master (
    input  has_wr_data, write_data_in, has_wr_adx, address_in, app_wdf_rdy, app_rdy,
    output get_wr_data, get_wr_adx, write_data_out, app_wdf_wren, app_wdf_end,
           app_en, app_cmd, address_out, credit_count
`ifdef WR_MASK_EN
    , input write_mask_in, output app_wdf_mask
`endif
  );

  modport slave (
    output has_wr_data, write_data_in, has_wr_adx, address_in, app_wdf_rdy, app_rdy,
    input  get_wr_data, get_wr_adx, write_data_out, app_wdf_wren, app_wdf_end,
           app_en, app_cmd, address_out, credit_count
`ifdef WR_MASK_EN
    , output write_mask_in, input app_wdf_mask
`endif
  );
endinterface

// File: rtl/fifo_to_app_wr_n.sv
// Drains write-data bursts and write addresses from two FIFOs into an app write port.
// Data may run ahead of commands by up to LEAD_MAX bursts. Optional byte mask: WR_MASK_EN.
module fifo_to_app_wr_n #(
  parameter int DATA_W     = 64,
  parameter int BEATS      = 2,
  parameter int ADDR_W     = 27,
  parameter int ALIGN_BITS = 3,
  parameter int LEAD_MAX   = 4
) (
  input logic                clk,
  input logic                reset,
  fifo_to_app_wr_n_if.master bus
);
  localparam int              BW         = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [3:0]      LEAD       = 4'(LEAD_MAX);
  localparam logic [BW-1:0]   LAST       = BW'(BEATS - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << ALIGN_BITS) - ADDR_W'(1));

  typedef enum logic [1:0] {D_IDLE, D_LOAD, D_BEAT}  d_state_t;
  typedef enum logic [1:0] {C_IDLE, C_LOAD, C_ISSUE} c_state_t;

  d_state_t d_state, d_nxt;
  c_state_t c_state, c_nxt;

  logic [BEATS-1:0][DATA_W-1:0] burst_q;
  logic [BW-1:0]                beat_q;
  logic [ADDR_W-1:0]            addr_q;
  logic [3:0]                   credit_q, credit_nxt;
  logic                         get_d, get_c;
  logic                         wren, beat_last, data_done, cmd_done;

  assign wren       = (d_state == D_BEAT);
  assign beat_last  = (beat_q == LAST);
  assign data_done  = wren && bus.app_wdf_rdy && beat_last;
  assign cmd_done   = (c_state == C_ISSUE) && bus.app_rdy;
  // A burst completing and a command retiring in the same cycle cancel out.
  assign credit_nxt = credit_q + 4'(data_done) - 4'(cmd_done);

  // Data path next state; a back-to-back pop is judged on the post-update credit.
  always_comb begin
    d_nxt = d_state;
    get_d = 1'b0;
    case (d_state)
      D_IDLE: if (bus.has_wr_data && credit_q < LEAD) begin
        get_d = 1'b1;
        d_nxt = D_LOAD;
      end
      D_LOAD: d_nxt = D_BEAT;
      D_BEAT: if (data_done) begin
        if (bus.has_wr_data && credit_nxt < LEAD) begin
          get_d = 1'b1;
          d_nxt = D_LOAD;
        end else begin
          d_nxt = D_IDLE;
        end
      end
      default: d_nxt = D_IDLE;
    endcase
  end

  always_comb begin
    c_nxt = c_state;
    get_c = 1'b0;
    case (c_state)
      C_IDLE: if (bus.has_wr_adx && credit_q != 4'd0) begin
        get_c = 1'b1;
        c_nxt = C_LOAD;
      end
      C_LOAD: c_nxt = C_ISSUE;
      C_ISSUE: if (cmd_done) begin
        if (bus.has_wr_adx && credit_nxt != 4'd0) begin
          get_c = 1'b1;
          c_nxt = C_LOAD;
        end else begin
          c_nxt = C_IDLE;
        end
      end
      default: c_nxt = C_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_state <= D_IDLE;
      beat_q  <= '0;
      burst_q <= '0;
    end else begin
      d_state <= d_nxt;
      if (d_state == D_LOAD) begin
        burst_q <= bus.write_data_in;
        beat_q  <= '0;
      end else if (wren && bus.app_wdf_rdy && !beat_last) begin
        beat_q <= beat_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_state  <= C_IDLE;
      addr_q   <= '0;
      credit_q <= '0;
    end else begin
      c_state  <= c_nxt;
      credit_q <= credit_nxt;
      if (c_state == C_LOAD) addr_q <= bus.address_in & ALIGN_MASK;
    end
  end

  // Pops are blocked while reset is held so nothing is taken and then discarded.
  assign bus.get_wr_data    = get_d && !reset;
  assign bus.get_wr_adx     = get_c && !reset;
  assign bus.app_wdf_wren   = wren;
  assign bus.app_wdf_end    = wren && beat_last;
  assign bus.write_data_out = wren ? burst_q[beat_q] : '1;
  assign bus.app_en         = (c_state == C_ISSUE);
  assign bus.app_cmd        = 3'b000;
  assign bus.address_out    = (c_state == C_ISSUE) ? addr_q : '1;
  assign bus.credit_count   = credit_q;

`ifdef WR_MASK_EN
  logic [BEATS-1:0][DATA_W/8-1:0] mask_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  mask_q <= '0;
    else if (d_state == D_LOAD) mask_q <= bus.write_mask_in;
  end

  assign bus.app_wdf_mask = wren ? mask_q[beat_q] : '0;
`endif
endmodule
